// File: rtl/note_display_sched_if.sv
// Producer-side note event handshake.
// Events move on an edge where note_valid and note_ready are both high.
interface note_display_sched_if;
  logic [3:0] note_in;
  logic [1:0] octave_in;
  logic       note_valid;
  logic       note_ready;

  modport master (
    output note_in, octave_in, note_valid,
    input  note_ready
  );

  modport slave (
    input  note_in, octave_in, note_valid,
    output note_ready
  );
endinterface

// File: rtl/note_display_sched.sv
// Paces buffered note events into one-at-a-time draw commands,
// assigning each to the next display row and holding it for the draw.
module note_display_sched #(
  parameter int          DEPTH       = 4,
  parameter int          SLOTS       = 4,
  parameter logic [7:0]  X0          = 8'd4,
  parameter logic [6:0]  Y0          = 7'd4,
  parameter logic [6:0]  Y_STEP      = 7'd16,
  parameter logic [14:0] INIT_CYCLES = 15'd19300,
  parameter logic [10:0] DRAW_CYCLES = 11'd1000
) (
  input  logic                     clk,
  input  logic                     reset,
  note_display_sched_if.slave      evt,
  output logic [3:0]               note,
  output logic [1:0]               octave,
  output logic [7:0]               x,
  output logic [6:0]               y,
  output logic                     ld_note,
  output logic                     busy,
  output logic                     bad_note,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_INIT, S_IDLE, S_LOAD, S_HOLD
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [5:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          r_avail;
  logic          r_bad;
  logic [14:0]   r_cnt;
  logic [2:0]    r_slot;
  logic [3:0]    r_note;
  logic [1:0]    r_oct;
  logic [7:0]    r_x;
  logic [6:0]    r_y;

  logic       w_full;
  logic       w_xfer;
  logic       w_good;
  logic       w_push;
  logic       w_pop;
  logic       w_init_done;
  logic       w_hold_done;
  logic [5:0] w_head;
  logic [6:0] w_y;

  assign w_full      = (r_count == CW'(DEPTH));
  assign w_xfer      = evt.note_valid & ~w_full;
  assign w_good      = (evt.note_in >= 4'd1) &&
                       (evt.note_in <= 4'd12);
  assign w_push      = w_xfer & w_good;
  assign w_head      = r_mem[r_rd];
  assign w_init_done = (r_cnt == INIT_CYCLES - 15'd1);
  assign w_hold_done = (r_cnt == '0);
  assign w_y         = Y0 + 7'(r_slot) * Y_STEP;

  assign evt.note_ready = ~w_full;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    unique case (r_state)
      S_INIT: if (w_init_done) w_state_nxt = S_IDLE;
      // r_avail lags the count so a fresh entry is seen a cycle late
      S_IDLE: if (r_avail && (r_count != '0)) begin
        w_pop       = 1'b1;
        w_state_nxt = S_LOAD;
      end
      S_LOAD: w_state_nxt = S_HOLD;
      S_HOLD: if (w_hold_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_INIT;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else begin
      unique case (r_state)
        S_INIT: r_cnt <= w_init_done ? '0 : r_cnt + 15'd1;
        S_LOAD: r_cnt <= 15'(DRAW_CYCLES) - 15'd1;
        S_HOLD: r_cnt <= w_hold_done ? '0 : r_cnt - 15'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_slot <= '0;
    end else if ((r_state == S_HOLD) && w_hold_done) begin
      r_slot <= (r_slot == 3'(SLOTS - 1)) ? '0 : r_slot + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= {evt.note_in, evt.octave_in};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_avail <= 1'b0;
      r_bad   <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      r_avail <= (r_count != '0);
      r_bad   <= w_xfer & ~w_good;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_note <= '0;
      r_oct  <= '0;
      r_x    <= X0;
      r_y    <= Y0;
    end else if (w_pop) begin
      r_note <= w_head[5:2];
      r_oct  <= w_head[1:0];
      r_x    <= X0;
      r_y    <= w_y;
    end
  end

  assign note       = r_note;
  assign octave     = r_oct;
  assign x          = r_x;
  assign y          = r_y;
  assign ld_note    = (r_state == S_LOAD);
  assign busy       = (r_count != '0) || (r_state != S_IDLE);
  assign bad_note   = r_bad;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_note_display_sched.sv
// Scoreboard bench for note_display_sched: expected draws queued
// at each accepted event, compared as ld_note strobes appear.
module tb_note_display_sched;

  localparam int INIT  = 19300;
  localparam int DRAW  = 1000;
  localparam int SPACE = DRAW + 2;

  typedef struct {
    logic [3:0] n;
    logic [1:0] o;
    logic [7:0] x;
    logic [6:0] y;
    int         c;
  } draw_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] note;
  logic [1:0] octave;
  logic [7:0] x;
  logic [6:0] y;
  logic       ld_note;
  logic       busy;
  logic       bad_note;
  logic [2:0] fifo_count;

  note_display_sched_if evt ();

  note_display_sched dut (
    .clk        (clk),
    .reset      (reset),
    .evt        (evt),
    .note       (note),
    .octave     (octave),
    .x          (x),
    .y          (y),
    .ld_note    (ld_note),
    .busy       (busy),
    .bad_note   (bad_note),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int    cyc = 0;
  int    n_pass = 0;
  int    n_total = 0;
  int    tb_slot = 0;
  int    last_acc = 0;
  draw_t exp_q[$];
  draw_t act_q[$];
  draw_t mon;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ld_note === 1'b1) begin
      mon.n = note;
      mon.o = octave;
      mon.x = x;
      mon.y = y;
      mon.c = cyc;
      act_q.push_back(mon);
    end
  end

  // Offer one event from a negedge; returns at the negedge after it lands.
  task automatic drive_evt(input logic [3:0] n, input logic [1:0] o,
                           output int waited);
    draw_t d;
    waited = 0;
    evt.note_in    = n;
    evt.octave_in  = o;
    evt.note_valid = 1'b1;
    while (evt.note_ready !== 1'b1 && waited < INIT + SPACE) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    @(negedge clk);
    last_acc       = cyc;
    evt.note_valid = 1'b0;
    if (n >= 4'd1 && n <= 4'd12) begin
      d.n = n;
      d.o = o;
      d.x = 8'd4;
      d.y = 7'(4 + 16 * tb_slot);
      d.c = 0;
      exp_q.push_back(d);
      tb_slot = (tb_slot + 1) % 4;
    end
  endtask

  task automatic wait_draws(input int n, input int budget);
    int k = 0;
    while (act_q.size() < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
  endtask

  task automatic wait_idle(output int k);
    k = 0;
    while (busy !== 1'b0 && k < 2 * SPACE) begin
      @(negedge clk); #1;
      k++;
    end
  endtask

  task automatic test_reset;
    int n = 0;
    int bad_xy = 0;
    evt.note_valid = 1'b0;
    evt.note_in    = 4'd0;
    evt.octave_in  = 2'd0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_total++; if (ld_note !== 1'b0) $display("FAIL rst_ld: got %b want 0", ld_note); else n_pass++;
    n_total++; if (fifo_count !== 3'd0) $display("FAIL rst_count: got %0d want 0", fifo_count); else n_pass++;
    n_total++; if (evt.note_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", evt.note_ready); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL rst_busy: got %b want 1", busy); else n_pass++;
    n_total++; if (x !== 8'd4 || y !== 7'd4) $display("FAIL rst_xy: got %0d,%0d want 4,4", x, y); else n_pass++;
    n_total++; if (note !== 4'd0 || octave !== 2'd0) $display("FAIL rst_note: got %0d,%0d want 0,0", note, octave); else n_pass++;
    n_total++; if (bad_note !== 1'b0) $display("FAIL rst_bad: got %b want 0", bad_note); else n_pass++;
    reset = 1'b1;
    while (busy === 1'b1 && n < INIT + 100) begin
      if (x !== 8'd4 || y !== 7'd4 || ld_note !== 1'b0) bad_xy++;
      n++;
      @(negedge clk); #1;
    end
    n_total++; if (n !== INIT) $display("FAIL init_len: got %0d want %0d", n, INIT); else n_pass++;
    n_total++; if (bad_xy !== 0) $display("FAIL init_hold: got %0d bad cycles want 0", bad_xy); else n_pass++;
    n_total++; if (act_q.size() !== 0) $display("FAIL init_ld: got %0d strobes want 0", act_q.size()); else n_pass++;
  endtask

  task automatic test_bad_code;
    int w;
    drive_evt(4'd0, 2'd1, w);
    #1;
    n_total++; if (bad_note !== 1'b1) $display("FAIL bad0_pulse: got %b want 1", bad_note); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (bad_note !== 1'b0) $display("FAIL bad0_width: got %b want 0", bad_note); else n_pass++;
    drive_evt(4'd13, 2'd0, w);
    #1;
    n_total++; if (bad_note !== 1'b1) $display("FAIL bad13_pulse: got %b want 1", bad_note); else n_pass++;
    repeat (5) @(negedge clk);
    #1;
    n_total++; if (bad_note !== 1'b0) $display("FAIL bad13_width: got %b want 0", bad_note); else n_pass++;
    n_total++; if (fifo_count !== 3'd0) $display("FAIL bad_count: got %0d want 0", fifo_count); else n_pass++;
    n_total++; if (act_q.size() !== 0) $display("FAIL bad_ld: got %0d strobes want 0", act_q.size()); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL bad_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_single;
    int    w;
    int    acc;
    int    unstable = 0;
    draw_t a;
    draw_t e;
    drive_evt(4'd5, 2'd2, w);
    acc = last_acc;
    wait_draws(1, 10);
    n_total++; if (act_q.size() !== 1) $display("FAIL single_ld: got %0d strobes want 1", act_q.size()); else n_pass++;
    if (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      n_total++; if (a.c - acc !== 2) $display("FAIL single_lat: got %0d want 2", a.c - acc); else n_pass++;
      n_total++; if (a.n !== e.n || a.o !== e.o) $display("FAIL single_note: got %0d/%0d want %0d/%0d", a.n, a.o, e.n, e.o); else n_pass++;
      n_total++; if (a.x !== e.x || a.y !== e.y) $display("FAIL single_xy: got %0d,%0d want %0d,%0d", a.x, a.y, e.x, e.y); else n_pass++;
      for (int i = 0; i < DRAW + 1; i++) begin
        @(negedge clk); #1;
        if (note !== e.n || octave !== e.o || x !== e.x || y !== e.y) unstable++;
      end
      n_total++; if (unstable !== 0) $display("FAIL single_hold: got %0d changed cycles want 0", unstable); else n_pass++;
      n_total++; if (act_q.size() !== 0) $display("FAIL single_width: got %0d extra strobes want 0", act_q.size()); else n_pass++;
    end
    wait_idle(w);
    n_total++; if (busy !== 1'b0) $display("FAIL single_idle: got busy %b want 0", busy); else n_pass++;
  endtask

  task automatic test_slot_wrap;
    logic [3:0] nl [5] = '{4'd1, 4'd12, 4'd7, 4'd3, 4'd9};
    logic [1:0] ol [5] = '{2'd0, 2'd3, 2'd1, 2'd2, 2'd0};
    int    w;
    int    prev = 0;
    draw_t a;
    draw_t e;
    for (int i = 0; i < 5; i++) drive_evt(nl[i], ol[i], w);
    n_total++; if (fifo_count !== 3'd4) $display("FAIL wrap_count: got %0d want 4", fifo_count); else n_pass++;
    n_total++; if (evt.note_ready !== 1'b0) $display("FAIL wrap_ready: got %b want 0", evt.note_ready); else n_pass++;
    wait_draws(5, 6 * SPACE);
    n_total++; if (act_q.size() !== 5) $display("FAIL wrap_draws: got %0d want 5", act_q.size()); else n_pass++;
    for (int i = 0; i < 5 && act_q.size() > 0 && exp_q.size() > 0; i++) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      n_total++; if (a.n !== e.n || a.o !== e.o) $display("FAIL wrap_note%0d: got %0d/%0d want %0d/%0d", i, a.n, a.o, e.n, e.o); else n_pass++;
      n_total++; if (a.x !== e.x || a.y !== e.y) $display("FAIL wrap_xy%0d: got %0d,%0d want %0d,%0d", i, a.x, a.y, e.x, e.y); else n_pass++;
      if (i > 0) begin
        n_total++; if (a.c - prev !== SPACE) $display("FAIL wrap_gap%0d: got %0d want %0d", i, a.c - prev, SPACE); else n_pass++;
      end
      prev = a.c;
    end
    wait_idle(w);
    n_total++; if (busy !== 1'b0) $display("FAIL wrap_idle: got busy %b want 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid_draw;
    int    w;
    int    n = 0;
    draw_t a;
    draw_t e;
    drive_evt(4'd2, 2'd1, w);
    drive_evt(4'd4, 2'd2, w);
    drive_evt(4'd6, 2'd3, w);
    wait_draws(1, 10);
    repeat (10) @(negedge clk);
    #1;
    n_total++; if (fifo_count !== 3'd2) $display("FAIL mid_queued: got %0d want 2", fifo_count); else n_pass++;
    if (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      n_total++; if (a.n !== e.n || a.y !== e.y) $display("FAIL mid_draw: got %0d@%0d want %0d@%0d", a.n, a.y, e.n, e.y); else n_pass++;
    end
    reset = 1'b0;
    @(negedge clk); #1;
    n_total++; if (fifo_count !== 3'd0) $display("FAIL mid_count: got %0d want 0", fifo_count); else n_pass++;
    n_total++; if (ld_note !== 1'b0) $display("FAIL mid_ld: got %b want 0", ld_note); else n_pass++;
    n_total++; if (y !== 7'd4 || x !== 8'd4) $display("FAIL mid_xy: got %0d,%0d want 4,4", x, y); else n_pass++;
    n_total++; if (note !== 4'd0 || octave !== 2'd0) $display("FAIL mid_note: got %0d,%0d want 0,0", note, octave); else n_pass++;
    n_total++; if (evt.note_ready !== 1'b1 || busy !== 1'b1) $display("FAIL mid_flags: got ready %b busy %b want 1 1", evt.note_ready, busy); else n_pass++;
    exp_q.delete();
    act_q.delete();
    tb_slot = 0;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;
    while (busy === 1'b1 && n < INIT + 100) begin
      n++;
      @(negedge clk); #1;
    end
    n_total++; if (n !== INIT) $display("FAIL mid_init_len: got %0d want %0d", n, INIT); else n_pass++;
    n_total++; if (act_q.size() !== 0) $display("FAIL mid_stale: got %0d strobes want 0", act_q.size()); else n_pass++;
  endtask

  task automatic test_back_pressure;
    logic [3:0] nl [5] = '{4'd3, 4'd8, 4'd12, 4'd1, 4'd11};
    logic [1:0] ol [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
    int    w;
    int    prev = 0;
    draw_t a;
    draw_t e;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    exp_q.delete();
    act_q.delete();
    tb_slot = 0;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) drive_evt(nl[i], ol[i], w);
    n_total++; if (fifo_count !== 3'd4) $display("FAIL bp_full: got %0d want 4", fifo_count); else n_pass++;
    n_total++; if (evt.note_ready !== 1'b0) $display("FAIL bp_ready: got %b want 0", evt.note_ready); else n_pass++;
    drive_evt(nl[4], ol[4], w);
    n_total++; if (w !== INIT - 3) $display("FAIL bp_stall: got %0d want %0d", w, INIT - 3); else n_pass++;
    n_total++; if (act_q.size() !== 1) $display("FAIL bp_first_pop: got %0d strobes want 1", act_q.size()); else n_pass++;
    n_total++; if (fifo_count !== 3'd4) $display("FAIL bp_refill: got %0d want 4", fifo_count); else n_pass++;
    wait_draws(5, 6 * SPACE);
    n_total++; if (act_q.size() !== 5) $display("FAIL bp_draws: got %0d want 5", act_q.size()); else n_pass++;
    for (int i = 0; i < 5 && act_q.size() > 0 && exp_q.size() > 0; i++) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      n_total++; if (a.n !== e.n || a.o !== e.o) $display("FAIL bp_note%0d: got %0d/%0d want %0d/%0d", i, a.n, a.o, e.n, e.o); else n_pass++;
      n_total++; if (a.y !== e.y) $display("FAIL bp_y%0d: got %0d want %0d", i, a.y, e.y); else n_pass++;
      if (i > 0) begin
        n_total++; if (a.c - prev !== SPACE) $display("FAIL bp_gap%0d: got %0d want %0d", i, a.c - prev, SPACE); else n_pass++;
      end
      prev = a.c;
    end
    wait_idle(w);
    n_total++; if (busy !== 1'b0 || fifo_count !== 3'd0) $display("FAIL bp_idle: got busy %b count %0d want 0 0", busy, fifo_count); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_bad_code();
    test_single();
    test_slot_wrap();
    test_reset_mid_draw();
    test_back_pressure();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
